// File: rtl/gn_tx_pkg.sv
// Shared types and constants for the golden nonce UART reporter.
package gn_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic [7:0] GN_HEADER_BYTE = 8'hA5;
    localparam int         GN_NONCE_BYTES = 4;

endpackage

// File: rtl/gn_fifo.sv
// Synchronous 32-bit nonce FIFO; a push while full is accepted only alongside a pop.
module gn_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     hash_clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [31:0]              push_data,
    input  logic                     pop,
    output logic [31:0]              pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full     = (count == (AW + 1)'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && (!full || pop);
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // When full, wr_ptr equals rd_ptr; the head is read before this edge overwrites it.
    always_ff @(posedge hash_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/golden_nonce_tx.sv
// Buffers golden nonces and sends each as little-endian UART 8N1 bytes.
// Define GN_TX_HEADER_EN to prefix every frame with the sync byte 8'hA5.
module golden_nonce_tx
    import gn_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                         hash_clk,
    input  logic                         reset_n,
    input  logic [31:0]                  golden_nonce_in,
    input  logic                         golden_nonce_match,
    output logic                         txd,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         overflow
);

    localparam int                 CNT_W      = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]   BIT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t         state;
    logic [31:0]       shift_reg;
    logic [2:0]        byte_idx;
    logic [2:0]        bit_idx;
    logic [CNT_W-1:0]  bit_cnt;
    logic              bit_done;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [31:0]       fifo_head;
    logic              is_header;
    logic [7:0]        cur_byte;

`ifdef GN_TX_HEADER_EN
    localparam logic [2:0] LAST_BYTE = 3'(GN_NONCE_BYTES);
    assign is_header = (byte_idx == 3'd0);
`else
    localparam logic [2:0] LAST_BYTE = 3'(GN_NONCE_BYTES - 1);
    assign is_header = 1'b0;
`endif

    assign cur_byte = is_header ? GN_HEADER_BYTE : shift_reg[7:0];
    assign bit_done = (bit_cnt == '0);
    assign pop      = (state == IDLE) && !fifo_empty;

    gn_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .hash_clk  (hash_clk),
        .reset_n   (reset_n),
        .push      (golden_nonce_match),
        .push_data (golden_nonce_in),
        .pop       (pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            byte_idx  <= '0;
            bit_idx   <= '0;
            bit_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        shift_reg <= fifo_head;
                        byte_idx  <= '0;
                        bit_cnt   <= BIT_RELOAD;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        bit_cnt <= BIT_RELOAD;
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        bit_cnt <= BIT_RELOAD;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        if (byte_idx < LAST_BYTE) begin
                            byte_idx <= byte_idx + 1'b1;
                            bit_cnt  <= BIT_RELOAD;
                            state    <= START;
                            // The header byte does not consume nonce bits.
                            if (!is_header) begin
                                shift_reg <= {8'h00, shift_reg[31:8]};
                            end
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line and busy are registered from the FSM, so they trail the state by one cycle.
    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            txd      <= 1'b1;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                START:   txd <= 1'b0;
                DATA:    txd <= cur_byte[bit_idx];
                default: txd <= 1'b1;
            endcase
            busy <= (state != IDLE) || !fifo_empty;
            if (golden_nonce_match && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_golden_nonce_tx.sv
// Scoreboard bench for golden_nonce_tx: queue model of the FIFO/transmitter plus a UART receiver.
module tb_golden_nonce_tx;

    localparam int C     = 4;
    localparam int DEPTH = 4;
`ifdef GN_TX_HEADER_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif
    localparam longint FRAME = NB * 10 * C;

    typedef struct {
        logic [31:0] v;
        longint      st;
    } exp_t;

    logic        hash_clk = 1'b0;
    logic        reset_n;
    logic [31:0] golden_nonce_in;
    logic        golden_nonce_match;
    logic        txd;
    logic        busy;
    logic [2:0]  fifo_count;
    logic        overflow;

    int     total = 0;
    int     bad   = 0;
    bit     started = 0;
    int     rst_gen = 0;

    logic [31:0] mq[$];
    exp_t        sbq[$];
    longint      cyc      = 0;
    longint      next_pop = 0;
    longint      last_pop = -1000000;
    bit          m_ovf    = 0;
    bit          m_busy   = 0;

    golden_nonce_tx #(
        .CLKS_PER_BIT(C),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .hash_clk          (hash_clk),
        .reset_n           (reset_n),
        .golden_nonce_in   (golden_nonce_in),
        .golden_nonce_match(golden_nonce_match),
        .txd               (txd),
        .busy              (busy),
        .fifo_count        (fifo_count),
        .overflow          (overflow)
    );

    always #5 hash_clk = ~hash_clk;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", name, got, expv);
        end
    endtask

    function automatic logic [39:0] frameBytes(input logic [31:0] v);
`ifdef GN_TX_HEADER_EN
        return {v, 8'hA5};
`else
        return {8'h00, v};
`endif
    endfunction

    // Reference model: a nonce leaves the queue when the line is free; a frame
    // occupies FRAME cycles and one idle cycle separates frames.
    always @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            sbq.delete();
            m_ovf    = 0;
            m_busy   = 0;
            next_pop = 0;
            last_pop = -1000000;
        end else begin
            cyc++;
            m_busy = ((cyc >= last_pop + 1) && (cyc <= last_pop + FRAME)) || (mq.size() != 0);
            if (mq.size() != 0 && cyc >= next_pop) begin
                exp_t e;
                e.v  = mq.pop_front();
                e.st = cyc + 1;
                sbq.push_back(e);
                last_pop = cyc;
                next_pop = cyc + FRAME + 1;
            end
            if (golden_nonce_match === 1'b1) begin
                if (mq.size() < DEPTH) mq.push_back(golden_nonce_in);
                else m_ovf = 1;
            end
        end
    end

    always @(negedge reset_n) rst_gen++;

    always @(negedge hash_clk) begin
        if (started && reset_n === 1'b1) begin
            checkOutput("fifo_count", 64'(fifo_count), 64'(mq.size()));
            checkOutput("overflow", 64'(overflow), 64'(m_ovf));
            checkOutput("busy", 64'(busy), 64'(m_busy));
        end
    end

    task automatic receiveFrame();
        int          gen  = rst_gen;
        longint      st   = cyc;
        int          errs = 0;
        logic [39:0] got  = '0;
        bit          have;
        exp_t        e;
        have = (sbq.size() != 0);
        if (have) e = sbq.pop_front();
        else checkOutput("unexpected_frame", 64'd1, 64'd0);
        for (int b = 0; b < NB; b++) begin
            if (b > 0) begin
                repeat (C) @(negedge hash_clk);
                if (rst_gen != gen) return;
            end
            if (txd !== 1'b0) errs++;
            for (int k = 0; k < 8; k++) begin
                repeat (C) @(negedge hash_clk);
                if (rst_gen != gen) return;
                got[8*b + k] = txd;
            end
            repeat (C) @(negedge hash_clk);
            if (rst_gen != gen) return;
            if (txd !== 1'b1) errs++;
        end
        checkOutput("framing", 64'(errs), 64'd0);
        if (have) begin
            checkOutput("frame_data", 64'(got), 64'(frameBytes(e.v)));
            checkOutput("frame_start", 64'(st), 64'(e.st));
        end
    endtask

    initial begin
        forever begin
            @(negedge hash_clk);
            if (started && reset_n === 1'b1 && txd === 1'b0) receiveFrame();
        end
    end

    task automatic applyStimulus(input logic [31:0] v);
        golden_nonce_match = 1'b1;
        golden_nonce_in    = v;
        @(negedge hash_clk);
        golden_nonce_match = 1'b0;
    endtask

    task automatic applyReset();
        reset_n = 1'b0;
        repeat (2) @(negedge hash_clk);
        reset_n = 1'b1;
        @(negedge hash_clk);
    endtask

    task automatic waitIdle(input int maxc);
        int n = 0;
        while ((mq.size() != 0 || sbq.size() != 0 || cyc < next_pop) && n < maxc) begin
            @(negedge hash_clk);
            n++;
        end
        if (n >= maxc) checkOutput("idle_timeout", 64'd1, 64'd0);
        repeat (2) @(negedge hash_clk);
        checkOutput("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        longint target;
        int     guard;
        golden_nonce_match = 1'b0;
        golden_nonce_in    = '0;
        reset_n            = 1'b0;
        repeat (3) @(negedge hash_clk);
        reset_n = 1'b1;
        @(negedge hash_clk);
        started = 1;
        checkOutput("reset_txd", 64'(txd), 64'd1);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_count", 64'(fifo_count), 64'd0);
        checkOutput("reset_ovf", 64'(overflow), 64'd0);

        $display("[TB] single nonce");
        applyStimulus(32'h12345678);
        waitIdle(2000);

        $display("[TB] burst of five");
        for (int i = 1; i <= 5; i++) applyStimulus(32'(i));
        waitIdle(5000);
        checkOutput("burst_ovf", 64'(overflow), 64'd0);

        $display("[TB] push and pop while full");
        for (int i = 0; i < 5; i++) applyStimulus(32'hA000_0000 + 32'(i));
        checkOutput("full_count", 64'(fifo_count), 64'd4);
        guard = 0;
        while (cyc != next_pop - 1 && guard < 1000) begin
            @(negedge hash_clk);
            guard++;
        end
        if (guard >= 1000) checkOutput("simul_wait_timeout", 64'd1, 64'd0);
        applyStimulus(32'hCAFEF00D);
        checkOutput("simul_count", 64'(fifo_count), 64'd4);
        checkOutput("simul_ovf", 64'(overflow), 64'd0);
        waitIdle(5000);

        $display("[TB] overflow");
        for (int i = 0; i < 6; i++) applyStimulus(32'hB000_0000 + 32'(i));
        checkOutput("ovf_set", 64'(overflow), 64'd1);
        checkOutput("ovf_count", 64'(fifo_count), 64'd4);
        waitIdle(5000);
        checkOutput("ovf_sticky", 64'(overflow), 64'd1);

        $display("[TB] reset mid-frame");
        applyReset();
        checkOutput("rst2_ovf", 64'(overflow), 64'd0);
        applyStimulus(32'h5A5A00C3);
        applyStimulus(32'h0BADF00D);
        target = cyc - 1 + 2 + 14 * C + 1;
        while (cyc < target) @(negedge hash_clk);
        checkOutput("rst_pre_txd", 64'(txd), 64'd0);
        #2 reset_n = 1'b0;
        #1 checkOutput("rst_async_txd", 64'(txd), 64'd1);
        repeat (2) @(negedge hash_clk);
        reset_n = 1'b1;
        @(negedge hash_clk);
        checkOutput("rst_count", 64'(fifo_count), 64'd0);
        checkOutput("rst_ovf", 64'(overflow), 64'd0);
        repeat (300) @(negedge hash_clk);
        checkOutput("rst_quiet_txd", 64'(txd), 64'd1);

        $display("[TB] random traffic");
        for (int r = 0; r < 15; r++) begin
            int gap   = $urandom_range(0, 180);
            int burst = $urandom_range(1, 3);
            repeat (gap) @(negedge hash_clk);
            for (int j = 0; j < burst; j++) applyStimulus($urandom);
        end
        waitIdle(20000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/golden_nonce_tx.md
# golden_nonce_tx

Serial reporter for golden nonces. Sits downstream of the hash core and consumes its one-cycle `golden_nonce_match` strobe with the accompanying 32-bit `golden_nonce_out` value. It buffers nonces in a small FIFO and transmits each one to the host as a UART 8N1 byte stream. Together with the shift loader, it closes the serial path to the host.

## Interface
- `CLKS_PER_BIT`, default 434: `hash_clk` cycles per UART bit; legal range 2..65535.
- `FIFO_DEPTH`, default 4: number of nonces buffered; power of two, 2..16.
- `hash_clk` in 1: single clock for the whole block.
- `reset_n` in 1: asynchronous, active-low reset.
- `golden_nonce_in` in 32: nonce value, sampled only when the match strobe is high.
- `golden_nonce_match` in 1: one-cycle strobe; each high cycle is one nonce.
- `txd` out 1: UART line; idle level 1.
- `busy` out 1: high while a frame is being sent or the FIFO is non-empty.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: number of nonces currently buffered.
- `overflow` out 1: sticky flag set when a nonce is dropped; cleared only by reset.

## Operation
- **Push**
  - Each cycle with `golden_nonce_match`=1 writes `golden_nonce_in` to the FIFO tail.
  - If the FIFO is full and no pop occurs in the same cycle, the new nonce is dropped and `overflow` is set. Buffered entries are never overwritten.
  - A push and a pop in the same cycle while full are both accepted; the count is unchanged and `overflow` is not set.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop the head into the 32-bit shift register, set byte index 0, and go to START.
  - START: drive `txd`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: send 8 bits LSB-first, each held `CLKS_PER_BIT` cycles, then go to STOP.
  - STOP: drive `txd`=1 for `CLKS_PER_BIT` cycles. Then, if the byte index is below 3, increment it and go to START. Otherwise go to IDLE.
- **Byte order:** nonce bytes are sent little-endian, [7:0] first and [31:24] last, matching host nonce byte order.
- **Frame gap:** there is no idle gap between bytes of a frame. Back-to-back frames are separated by exactly one IDLE cycle.
- **Bit counter:** counts down from `CLKS_PER_BIT`-1 to 0. Its width is $clog2(CLKS_PER_BIT). Wrap-around is never relied on.
- **Reset values:** `txd`=1, `busy`=0, `fifo_count`=0, `overflow`=0, FSM in IDLE, FIFO pointers at 0.
- **Reset mid-frame:** asserting `reset_n` low forces `txd` to 1 immediately, without waiting for a clock edge. The partial frame and all buffered nonces are discarded.

## Timing
- A strobe at edge N is visible in `fifo_count` after edge N.
- From an empty, idle block, the pop occurs at edge N+1 and `txd` falls at edge N+2. Push-to-start-bit latency is therefore 2 cycles.
- One frame (4 bytes) lasts 40×`CLKS_PER_BIT` cycles, or 50×`CLKS_PER_BIT` with the header enabled.
- `busy` rises at the edge after the push and falls at the end of the last stop bit, provided the FIFO is empty.
- Strobes arriving while a frame is in flight are queued. They are never lost unless the FIFO is full.

## Configuration
- `GN_TX_HEADER_EN`
  - Defined: each frame is preceded by the sync byte 8'hA5, sent with normal 8N1 framing. The byte index runs 0..4, and index 0 is the header.
  - Undefined: no header byte; the byte index runs 0..3 and frames carry only the nonce bytes.

## Structure
- Package `gn_tx_pkg` holds:
  - the state enum (IDLE, START, DATA, STOP);
  - `GN_HEADER_BYTE` = 8'hA5;
  - `GN_NONCE_BYTES` = 4.
- Sub-module `gn_fifo` is a synchronous FIFO with parameter `DEPTH` and width 32. It provides push, pop, count and full/empty, and handles simultaneous push+pop when full. The top level contains only the UART FSM and the overflow logic.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.
1. **Single nonce.** Strobe 32'h12345678 → `txd` falls 2 cycles later. Bytes 78,56,34,12 are sent LSB-first, each with one start and one stop bit. The frame lasts 160 cycles, after which `busy`=0.
2. **Burst of 5.** Strobe 5 consecutive cycles with values 1..5 → nonce 1 is popped and 2..5 are queued, so no overflow. Five frames follow in order, each separated by 1 idle cycle.
3. **Overflow.** Strobe 6 values in consecutive cycles while a frame is in flight → the 6th is dropped, `overflow`=1 and stays high, `fifo_count` peaks at 4, and only 5 frames are sent.
4. **Simultaneous push/pop when full.** Push in the same cycle as an IDLE pop with `fifo_count`=4 → the nonce is accepted, `overflow` stays 0, and `fifo_count` stays 4.
5. **Reset mid-frame.** Assert `reset_n`=0 during DATA bit 3 of byte 1 → `txd`=1 without a clock edge. After release, `fifo_count`=0, `overflow`=0, and no further frames are sent.
6. **Header enabled.** With `GN_TX_HEADER_EN` defined, strobe 32'hDEADBEEF → bytes A5,EF,BE,AD,DE are sent over 200 cycles.
